mem_req_arbiter: RTL

//  Shares the single LSU request port between two requesters: r0 = IFU fetch, r1 = EXU load/store.

---
 rtl/mem_req_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
//
// Shares the single LSU request port between two requesters: r0 (IFU fetch)
// and r1 (EXU load/store). One transaction is in flight at a time:
//   IDLE  -> pick a winner (round-robin on ties) and latch its request
//   ISSUE -> one-cycle mem_valid pulse to the LSU
//   WAIT  -> wait for mem_ready, or give up after TIMEOUT_CYCLES cycles
//   RESP  -> one-cycle rN_ready pulse (with rN_rdata / rN_err) to the winner
// A timeout turns an LSU that never answers (e.g. an AXI error response)
// into an error completion so the requester is never stuck.
// Every output comes from a flop, so there is no combinational input->output path.
//
// Parameters
//   ADDR_W          address width
//   DATA_W          data width (byte strobes are DATA_W/8 wide)
//   TIMEOUT_CYCLES  WAIT cycles before a forced error completion (>= 2)
//
// Ports
//   clock, reset                 clock, synchronous active-high reset
//   r{0,1}_valid/addr/wen/       request, held stable until rN_ready
//     wdata/wmask
//   r{0,1}_ready/rdata/err       one-cycle completion, read data, timeout flag
//   mem_valid                    one-cycle request pulse to the LSU
//   mem_addr/wen/wdata/wmask     latched request fields, held until next grant
//   mem_ready, mem_rdata         LSU completion pulse and read data
// -----------------------------------------------------------------------------
module mem_req_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                clock,
  input  logic                reset,
  // requester 0 (IFU)
  input  logic                r0_valid,
  input  logic [ADDR_W-1:0]   r0_addr,
  input  logic                r0_wen,
  input  logic [DATA_W-1:0]   r0_wdata,
  input  logic [DATA_W/8-1:0] r0_wmask,
  output logic                r0_ready,
  output logic [DATA_W-1:0]   r0_rdata,
  output logic                r0_err,
  // requester 1 (EXU)
  input  logic                r1_valid,
  input  logic [ADDR_W-1:0]   r1_addr,
  input  logic                r1_wen,
  input  logic [DATA_W-1:0]   r1_wdata,
  input  logic [DATA_W/8-1:0] r1_wmask,
  output logic                r1_ready,
  output logic [DATA_W-1:0]   r1_rdata,
  output logic                r1_err,
  // LSU port
  output logic                mem_valid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e              state_q,     state_d;
  // Requester that wins the next tie. Reset 0 gives r0 the first tie; after
  // every grant it points at the requester that was not served.
  logic                rr_ptr_q,    rr_ptr_d;
  logic                grant_q,     grant_d;      // owner of the transaction in flight
  logic [CNT_W-1:0]    cnt_q,       cnt_d;        // WAIT cycles elapsed
  logic                mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic                mem_wen_q,   mem_wen_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0]   mem_wmask_q, mem_wmask_d;
  logic                r0_ready_q,  r0_ready_d;
  logic [DATA_W-1:0]   r0_rdata_q,  r0_rdata_d;
  logic                r0_err_q,    r0_err_d;
  logic                r1_ready_q,  r1_ready_d;
  logic [DATA_W-1:0]   r1_rdata_q,  r1_rdata_d;
  logic                r1_err_q,    r1_err_d;

  // WAIT-state completion, routed to the winner below
  logic                resp_fire;
  logic                resp_err;
  logic [DATA_W-1:0]   resp_rdata;
  logic                pick;

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    mem_valid_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wen_d   = mem_wen_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    r0_ready_d  = 1'b0;
    r0_rdata_d  = '0;
    r0_err_d    = 1'b0;
    r1_ready_d  = 1'b0;
    r1_rdata_d  = '0;
    r1_err_d    = 1'b0;
    resp_fire   = 1'b0;
    resp_err    = 1'b0;
    resp_rdata  = '0;
    pick        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (r0_valid || r1_valid) begin
          if (r0_valid && r1_valid) pick = rr_ptr_q;
          else                      pick = r1_valid;
          grant_d     = pick;
          rr_ptr_d    = ~pick;
          mem_addr_d  = pick ? r1_addr  : r0_addr;
          mem_wen_d   = pick ? r1_wen   : r0_wen;
          mem_wdata_d = pick ? r1_wdata : r0_wdata;
          mem_wmask_d = pick ? r1_wmask : r0_wmask;
          mem_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // mem_ready has priority over a timeout landing on the same cycle
        if (mem_ready) begin
          resp_fire  = 1'b1;
          resp_rdata = mem_wen_q ? '0 : mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The response flops are loaded on the last WAIT cycle so they are high
    // exactly during RESP; the loser's outputs keep their zero defaults.
    if (resp_fire) begin
      state_d    = S_RESP;
      r0_ready_d = ~grant_q;
      r0_rdata_d = grant_q ? '0 : resp_rdata;
      r0_err_d   = ~grant_q & resp_err;
      r1_ready_d = grant_q;
      r1_rdata_d = grant_q ? resp_rdata : '0;
      r1_err_d   = grant_q & resp_err;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 1'b0;
      grant_q     <= 1'b0;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      r0_ready_q  <= 1'b0;
      r0_rdata_q  <= '0;
      r0_err_q    <= 1'b0;
      r1_ready_q  <= 1'b0;
      r1_rdata_q  <= '0;
      r1_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      r0_ready_q  <= r0_ready_d;
      r0_rdata_q  <= r0_rdata_d;
      r0_err_q    <= r0_err_d;
      r1_ready_q  <= r1_ready_d;
      r1_rdata_q  <= r1_rdata_d;
      r1_err_q    <= r1_err_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wen   = mem_wen_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign r0_ready  = r0_ready_q;
  assign r0_rdata  = r0_rdata_q;
  assign r0_err    = r0_err_q;
  assign r1_ready  = r1_ready_q;
  assign r1_rdata  = r1_rdata_q;
  assign r1_err    = r1_err_q;

endmodule
